// File: rtl/spram_pkg.sv
// Shared types and constants for the SPRAM Wishbone bridge.
// States, default depth and the Wishbone word-address slice.
package spram_pkg;

  localparam int WORDS_DEF = 32768;
  localparam int ADR_LSB   = 2;
  localparam int ADR_MSB   = 16;
  localparam int RAM_AW    = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ACK   = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/spram_clear.sv
// Post-reset clear sequencer: walks every word once, one per cycle.
// Only instantiated when SPRAM_CLEAR_EN is defined.
module spram_clear
  import spram_pkg::*;
#(
  parameter int WORDS = WORDS_DEF,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          start,
  output logic          busy,
  output logic          last,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] TOP = AW'(WORDS - 1);

  assign last = busy && (addr == TOP);

  always_ff @(posedge clk) begin
    if (start) begin
      busy <= 1'b1;
      addr <= '0;
    end else if (busy) begin
      addr <= addr + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/spram_wb_bridge.sv
// Wishbone classic slave onto a single-port SPRAM wrapper.
// Define SPRAM_CLEAR_EN to zero the whole array after every reset.
module spram_wb_bridge
  import spram_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_rdt,
  output logic        wb_ack,
  output logic        busy,
  output logic [3:0]  ram_wen,
  output logic [21:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t state;
  state_t state_n;
  logic   req;
  logic   acc_wr;

  // Upper address bits alias onto the same words by design.
  logic unused_adr;
  assign unused_adr =
    ^{wb_adr[31:ADR_MSB+1], wb_adr[ADR_LSB-1:0]};

  assign wb_ack = (state == ACK);
  assign req    = wb_cyc & wb_stb & ~wb_ack;
  assign acc_wr = ~rst & (state == IDLE) & req & wb_we;

`ifdef SPRAM_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;

  logic          clr_busy;
  logic          clr_last;
  logic [AW-1:0] clr_addr;

  spram_clear #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_clear (
    .clk   (clk),
    .start (rst),
    .busy  (clr_busy),
    .last  (clr_last),
    .addr  (clr_addr)
  );

  assign busy = clr_busy;
`else
  localparam state_t RST_STATE = IDLE;
  localparam int unused_aw = AW;

  assign busy = 1'b0;
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (req) state_n = wb_we ? ACK : READ;
      READ:  state_n = ACK;
      ACK:   state_n = IDLE;
`ifdef SPRAM_CLEAR_EN
      CLEAR: if (clr_last) state_n = IDLE;
`else
      CLEAR: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RST_STATE;
      wb_rdt <= '0;
    end else begin
      state <= state_n;
      if (state == READ) wb_rdt <= ram_rdata;
    end
  end

  always_comb begin
    ram_wen   = 4'h0;
    ram_wdata = wb_dat;
    ram_addr  = RAM_AW'(wb_adr[ADR_MSB:ADR_LSB]);
    if (acc_wr) ram_wen = wb_sel;
`ifdef SPRAM_CLEAR_EN
    if (!rst && state == CLEAR) begin
      ram_wen   = 4'hF;
      ram_wdata = '0;
      ram_addr  = RAM_AW'(clr_addr);
    end
`endif
  end

endmodule

// File: doc/spram_wb_bridge.md
SPRAM_WB_BRIDGE -- requirements
Module: spram_wb_bridge

Interface
REQ-001 The block SHALL have parameter WORDS, default 32768, giving the number of 32-bit SPRAM words served; it SHALL be a power of two and no greater than 32768.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have the port wb_adr, input, 32 bits: Wishbone byte address.
REQ-005 The block SHALL have the ports wb_dat (input, 32 bits) and wb_sel (input, 4 bits): Wishbone write data and byte selects.
REQ-006 The block SHALL have the ports wb_we, wb_cyc and wb_stb (inputs, 1 bit each): Wishbone write enable, cycle and strobe.
REQ-007 The block SHALL have the ports wb_rdt (output, 32 bits, registered read data) and wb_ack (output, 1 bit, one-cycle acknowledge).
REQ-008 The block SHALL have the port busy, output, 1 bit: high while the post-reset clear is running.
REQ-009 The block SHALL have the ports ram_wen (output, 4), ram_addr (output, 22), ram_wdata (output, 32) and ram_rdata (input, 32): the SPRAM wrapper port set.

Function
REQ-010 Request = wb_cyc & wb_stb & !wb_ack; it SHALL be accepted only in state IDLE.
REQ-011 The word address SHALL be wb_adr[16:2], zero-extended to 22 bits onto ram_addr; wb_adr[31:17] and [1:0] SHALL be ignored (aliasing is permitted).
REQ-012 Write accept cycle: ram_wen = wb_sel, ram_wdata = wb_dat, combinational. The block SHALL go IDLE->ACK, giving wb_ack in the next cycle (latency 1).
REQ-013 A write with wb_sel = 0 SHALL still be acknowledged with ram_wen = 0.
REQ-014 Read accept cycle: ram_wen = 0 and ram_addr is driven. The block SHALL go IDLE->READ, capture ram_rdata into wb_rdt at the end of READ, then go READ->ACK; wb_ack SHALL rise 2 cycles after accept.
REQ-015 ACK SHALL last exactly one cycle, then the block SHALL return to IDLE; wb_ack SHALL never be high on two consecutive cycles.
REQ-016 wb_rdt SHALL hold its last captured value until the next read completes; writes SHALL NOT alter it.
REQ-017 Outside write-accept and CLEAR, ram_wen SHALL be 0.
REQ-018 If wb_cyc drops while in READ, the block SHALL still complete to ACK, then IDLE, with no side effect.
REQ-019 In CLEAR, requests SHALL be stalled without ack and SHALL be accepted in the first IDLE cycle after CLEAR ends.

Reset
REQ-020 On rst: wb_ack = 0, wb_rdt = 0 and ram_wen = 0. The state SHALL go to CLEAR if SPRAM_CLEAR_EN is defined, else to IDLE.
REQ-021 rst asserted mid-transaction SHALL abandon it with no ack. rst asserted mid-clear SHALL restart the clear from word 0.

Configuration
REQ-022 Macro SPRAM_CLEAR_EN defined: after reset, a clear SHALL run in which ram_addr counts 0..WORDS-1, one word per cycle, with ram_wen = 4'hF and ram_wdata = 0. busy SHALL be high for exactly WORDS cycles, after which the block enters IDLE.
REQ-023 SPRAM_CLEAR_EN undefined: there SHALL be no clear logic, busy SHALL be tied 0, and reset SHALL go straight to IDLE.

Structure
REQ-024 Package spram_pkg SHALL hold the state enum (IDLE, READ, ACK, CLEAR), the WORDS default and the address-slice constants (ADR_LSB = 2, ADR_MSB = 16).
REQ-025 Sub-module spram_clear SHALL hold the clear counter (start, busy, addr out), and SHALL be instantiated only under SPRAM_CLEAR_EN.

Verification
REQ-026 Write wb_adr = 0x00000010, wb_dat = 0xDEADBEEF, wb_sel = 0xF -> in the same cycle ram_addr = 4 and ram_wen = 0xF; wb_ack is high in the next cycle.
REQ-027 Read back 0x00000010 with a RAM model -> wb_ack 2 cycles after accept with wb_rdt = 0xDEADBEEF; ram_wen = 0 throughout.
REQ-028 Byte write wb_sel = 0x4, wb_dat = 0x00AA0000 to 0x10, then a read -> wb_rdt = 0xDEAABEEF.
REQ-029 Address 0x00010000 -> ram_addr = 0x4000 (upper bank); a write to 0x00020010 aliases to ram_addr = 4.
REQ-030 SPRAM_CLEAR_EN, WORDS = 16: busy is high for 16 cycles with ram_addr 0..15 and ram_wen = 0xF; a request made during the clear acks only after busy falls; rst applied at word 8 restarts the clear from 0.
REQ-031 Back-to-back reads with wb_stb held high -> each ack is one cycle, acks are spaced 3 cycles apart, and there is never a double ack.
